// File: rtl/nf10_axis_pkt_store_fwd_pkg.sv
// rtl/nf10_axis_pkt_store_fwd_pkg.sv - write FSM encodings and RAM word layout helpers
package nf10_axis_pkt_store_fwd_pkg;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_PKT  = 2'd1,
    WR_DROP = 2'd2
  } wr_state_e;

  // RAM word is {tlast, tuser, tstrb, tdata}
  function automatic int ram_width(input int data_w, input int user_w);
    return 1 + user_w + data_w / 8 + data_w;
  endfunction

endpackage

// File: rtl/nf10_sdp_bram.sv
// rtl/nf10_sdp_bram.sv - simple dual-port RAM, one write port, one registered read port
module nf10_sdp_bram #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_q [2**ADDR_W];
  logic [WIDTH-1:0] rd_data_q;

  // Read register holds its value when rd_en is low; the top relies on this for skid stability.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/nf10_axis_pkt_store_fwd.sv
// rtl/nf10_axis_pkt_store_fwd.sv - store-and-forward AXI4-Stream packet buffer with oversize drop
module nf10_axis_pkt_store_fwd
  import nf10_axis_pkt_store_fwd_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_DEPTH_LOG2       = 9
) (
  input  logic                            aclk,
  input  logic                            reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [C_DEPTH_LOG2:0]           pkt_count,
  output logic [7:0]                      drop_count,
  output logic                            drop_pulse
);

  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int SW = C_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_AXIS_TUSER_WIDTH;
  localparam int AW = C_DEPTH_LOG2;
  localparam int PW = C_DEPTH_LOG2 + 1;
  localparam int RW = ram_width(C_AXIS_DATA_WIDTH, C_AXIS_TUSER_WIDTH);
  localparam logic [PW-1:0] DEPTH_P = {1'b1, {AW{1'b0}}};

  wr_state_e     state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] fetch_ptr_q, fetch_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] pkt_count_q, pkt_count_d;
  logic [7:0]    drop_count_q, drop_count_d;
  logic          drop_pulse_q, drop_pulse_d;
  logic          s_tready_q, s_tready_d;
  logic          ram_vld_q, ram_vld_d;
  logic [1:0]    sk_cnt_q, sk_cnt_d;
  logic [RW-1:0] sk0_q, sk0_d, sk1_q, sk1_d;

  logic [RW-1:0] s_word, ram_rdata, m_head, m_out;
  logic          s_xfer, m_xfer, m_valid, head_last, full, commit_evt;
  logic          ram_we, issue, pop_sk, pop_ram, move;

  assign s_word    = {s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata};
  assign s_xfer    = s_axis_tvalid && s_tready_q;
  assign ram_we    = s_xfer && (state_q != WR_DROP);
  // rd_ptr frees slots only when a beat leaves, so beats held in the skid still count toward full.
  assign full      = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
  assign m_valid   = (sk_cnt_q != 2'd0) || ram_vld_q;
  assign m_head    = (sk_cnt_q != 2'd0) ? sk0_q : ram_rdata;
  assign head_last = m_head[RW-1];
  assign m_xfer    = m_valid && m_axis_tready;
  assign issue     = (fetch_ptr_q != commit_ptr_q) && !((sk_cnt_q == 2'd2) && ram_vld_q);
  assign pop_sk    = m_xfer && (sk_cnt_q != 2'd0);
  assign pop_ram   = m_xfer && (sk_cnt_q == 2'd0);
  assign move      = ram_vld_q && !pop_ram && issue;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    drop_count_d = drop_count_q;
    drop_pulse_d = 1'b0;
    commit_evt   = 1'b0;
    case (state_q)
      WR_IDLE, WR_PKT: begin
        if (s_xfer) begin
          wr_ptr_d = wr_ptr_q + PW'(1);
          if (s_axis_tlast) begin
            commit_ptr_d = wr_ptr_q + PW'(1);
            commit_evt   = 1'b1;
            state_d      = WR_IDLE;
          end else begin
            state_d = WR_PKT;
          end
        end else if ((state_q == WR_PKT) && full && (commit_ptr_q == rd_ptr_q)) begin
          wr_ptr_d = commit_ptr_q;
          state_d  = WR_DROP;
        end
      end
      WR_DROP: begin
        if (s_xfer && s_axis_tlast) begin
          drop_pulse_d = 1'b1;
          drop_count_d = drop_count_q + 8'd1;
          state_d      = WR_IDLE;
        end
      end
      default: state_d = WR_IDLE;
    endcase
  end

  always_comb begin
    fetch_ptr_d = issue ? fetch_ptr_q + PW'(1) : fetch_ptr_q;
    rd_ptr_d    = m_xfer ? rd_ptr_q + PW'(1) : rd_ptr_q;
    pkt_count_d = pkt_count_q;
    if (commit_evt && !(m_xfer && head_last)) pkt_count_d = pkt_count_q + PW'(1);
    else if (!commit_evt && m_xfer && head_last) pkt_count_d = pkt_count_q - PW'(1);
    s_tready_d = (state_d == WR_DROP) || ((wr_ptr_d - rd_ptr_d) != DEPTH_P);
  end

  // Skid entries are older than the RAM register; a pending RAM beat moves in before a new read lands.
  always_comb begin
    sk0_d    = sk0_q;
    sk1_d    = sk1_q;
    sk_cnt_d = sk_cnt_q;
    if (pop_sk) begin
      sk0_d    = sk1_q;
      sk_cnt_d = sk_cnt_q - 2'd1;
    end
    if (move) begin
      if (sk_cnt_d == 2'd0) sk0_d = ram_rdata;
      else                  sk1_d = ram_rdata;
      sk_cnt_d = sk_cnt_d + 2'd1;
    end
    if (issue)        ram_vld_d = 1'b1;
    else if (pop_ram) ram_vld_d = 1'b0;
    else              ram_vld_d = ram_vld_q;
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q      <= WR_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      fetch_ptr_q  <= '0;
      rd_ptr_q     <= '0;
      pkt_count_q  <= '0;
      drop_count_q <= '0;
      drop_pulse_q <= 1'b0;
      s_tready_q   <= 1'b1;
      ram_vld_q    <= 1'b0;
      sk_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      fetch_ptr_q  <= fetch_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
      drop_pulse_q <= drop_pulse_d;
      s_tready_q   <= s_tready_d;
      ram_vld_q    <= ram_vld_d;
      sk_cnt_q     <= sk_cnt_d;
    end
  end

  always_ff @(posedge aclk) begin
    sk0_q <= sk0_d;
    sk1_q <= sk1_d;
  end

  nf10_sdp_bram #(
    .WIDTH  (RW),
    .ADDR_W (AW)
  ) u_bram (
    .clk     (aclk),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (s_word),
    .rd_en   (issue),
    .rd_addr (fetch_ptr_q[AW-1:0]),
    .rd_data (ram_rdata)
  );

  assign m_out         = m_valid ? m_head : '0;
  assign m_axis_tdata  = m_out[DW-1:0];
  assign m_axis_tstrb  = m_out[DW+SW-1:DW];
  assign m_axis_tuser  = m_out[DW+SW+UW-1:DW+SW];
  assign m_axis_tlast  = m_out[RW-1];
  assign m_axis_tvalid = m_valid;
  assign s_axis_tready = s_tready_q;
  assign pkt_count     = pkt_count_q;
  assign drop_count    = drop_count_q;
  assign drop_pulse    = drop_pulse_q;

endmodule
